acc_mem_arbiter: RTL
====================

ACC_MEM_ARBITER -- requirements
Module: acc_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_ACC, default 4: number of accelerator control units served.
REQ-002 SHALL have parameter ADDR_W, default 16: memory address width.
REQ-003 SHALL have parameter RD_DATA_W, default 512: read line width.
REQ-004 SHALL have parameter WR_DATA_W, default 32: write word width.
REQ-005 SHALL have parameter MEM_RD_LATENCY, default 1: cycles from mem_en (read) to mem_rd_data valid; legal range is 1..15.
REQ-006 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port cpu_busy, input, 1 bit: CPU owns the memory, so no new grant is made.
REQ-009 SHALL have port acc_read_en, input, NUM_ACC bits: per-accelerator read request, level, held until its valid pulse.
REQ-010 SHALL have port acc_read_addr, input, NUM_ACC*ADDR_W bits: packed read addresses; slice i belongs to accelerator i.
REQ-011 SHALL have port acc_write_en, input, NUM_ACC bits: per-accelerator write request, level, held until its done pulse.
REQ-012 SHALL have port acc_write_addr, input, NUM_ACC*ADDR_W bits: packed write addresses.
REQ-013 SHALL have port acc_write_data, input, NUM_ACC*WR_DATA_W bits: packed write data.
REQ-014 SHALL have port acc_read_data, output, RD_DATA_W bits: registered read line, broadcast to all accelerators.
REQ-015 SHALL have port acc_read_data_valid, output, NUM_ACC bits: one-hot, one-cycle read completion pulse.
REQ-016 SHALL have port acc_write_done, output, NUM_ACC bits: one-hot, one-cycle write completion pulse.
REQ-017 SHALL have ports mem_en (output, 1 bit), mem_we (output, 1 bit), mem_addr (output, ADDR_W bits) and mem_wr_data (output, WR_DATA_W bits): memory command.
REQ-018 SHALL have port mem_rd_data, input, RD_DATA_W bits: memory read return.

Function
REQ-019 SHALL implement an FSM with states IDLE, ISSUE, WAIT_RD and DONE.
REQ-020 IDLE: if cpu_busy=0 and any request is pending, SHALL select an accelerator by round-robin starting at pointer rr_ptr, latch its index, op, address and data, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 If one accelerator asserts both read and write, SHALL serve the write first.
REQ-022 ISSUE: SHALL drive mem_en=1, mem_we=op, mem_addr and mem_wr_data from the latched values for exactly one cycle; a write then goes to DONE, a read goes to WAIT_RD with the counter loaded to MEM_RD_LATENCY.
REQ-023 WAIT_RD: SHALL decrement the counter each cycle; on the cycle the counter reaches 1, SHALL register mem_rd_data into acc_read_data and go to DONE.
REQ-024 DONE: SHALL pulse acc_write_done[idx] or acc_read_data_valid[idx] for one cycle, set rr_ptr to (idx+1) mod NUM_ACC, and return to IDLE.
REQ-025 Latency, with the request sampled in IDLE at cycle T: write done pulse at T+2; read valid pulse at T+2+MEM_RD_LATENCY.
REQ-026 mem_en, mem_we, mem_addr and mem_wr_data SHALL be 0 in every state except ISSUE.
REQ-027 acc_read_data SHALL hold its last captured value until the next read capture.
REQ-028 A request that drops after being latched SHALL still be completed and pulsed; cpu_busy SHALL be sampled in IDLE only.
REQ-029 The minimum gap between grants SHALL be one IDLE cycle, so a requester's same-cycle state change is never mistaken for a new request.

Reset
REQ-030 On rst_n=0: state=IDLE, rr_ptr=0, counter=0, acc_read_data=0, all pulses 0, all mem_* outputs 0.
REQ-031 Reset mid-transaction SHALL abort it with no completion pulse.

Structure
REQ-032 The state enum and default widths SHALL live in shared package acc_pkg.
REQ-033 The round-robin selection SHALL be a combinational sub-module acc_rr_picker (inputs: request vector and pointer; outputs: grant index and any-request flag).

Verification
REQ-034 A single write from acc 2 (addr 0x5000, data 0x5) -> mem_we=1 at T+1 and acc_write_done=4'b0100 at T+2.
REQ-035 A read from acc 0 (addr 0x1000), with MEM_RD_LATENCY=3 and mem_rd_data=0xA5..A5 -> acc_read_data_valid=4'b0001 at T+5, and acc_read_data equals the pattern.
REQ-036 All four accelerators write simultaneously -> done pulses in order acc0, acc1, acc2, acc3, then a re-request is served starting at acc0 after acc3.
REQ-037 cpu_busy=1 with pending requests for 10 cycles -> mem_en stays 0; service starts the cycle after cpu_busy falls.
REQ-038 rst_n=0 during WAIT_RD -> no valid pulse, and the next read starts with rr_ptr=0.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared types and defaults for the accelerator memory arbiter.
//   state_t     - arbiter FSM states
//   DEF_*       - default parameter values used by acc_mem_arbiter
//   CNT_W       - read-latency counter width (latency range 1..15)
//   idx_w()     - index width for a requester count (never below 1)
package acc_pkg;

  localparam int DEF_NUM_ACC        = 4;
  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_RD_DATA_W      = 512;
  localparam int DEF_WR_DATA_W      = 32;
  localparam int DEF_MEM_RD_LATENCY = 1;
  localparam int CNT_W              = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_rr_picker.sv
// acc_rr_picker: combinational round-robin selector.
//   req     - request vector, one bit per requester
//   ptr     - highest-priority requester this round
//   grant   - index of the first requesting slot at or after ptr (wraps)
//   any_req - at least one request bit set
module acc_rr_picker
  import acc_pkg::*;
#(
  parameter int NUM_ACC = DEF_NUM_ACC,
  parameter int IDX_W   = idx_w(NUM_ACC)
) (
  input  logic [NUM_ACC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  int               c;
  logic [IDX_W-1:0] ci;
  logic             found;

  // Walk the slots starting at ptr; the first request seen wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_ACC) c = c - NUM_ACC;
      ci = IDX_W'(c);
      if (!found && req[ci]) begin
        found = 1'b1;
        grant = ci;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/acc_mem_arbiter.sv
// acc_mem_arbiter: shares one memory port among NUM_ACC accelerators.
// One transaction at a time: IDLE picks a requester round-robin, ISSUE drives
// the memory command for one cycle, WAIT_RD counts out the read latency and
// captures the line, DONE pulses the one-hot completion and advances rr_ptr.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   cpu_busy            - CPU owns memory; blocks new grants (IDLE only)
//   acc_read_en/addr    - per-accelerator read request (level) and address
//   acc_write_en/addr/data - per-accelerator write request, address, data
//   acc_read_data       - captured read line, shared by all accelerators
//   acc_read_data_valid - one-hot read completion pulse
//   acc_write_done      - one-hot write completion pulse
//   mem_en/we/addr/wr_data - memory command, nonzero only in ISSUE
//   mem_rd_data         - memory read return, MEM_RD_LATENCY after mem_en
module acc_mem_arbiter
  import acc_pkg::*;
#(
  parameter int NUM_ACC        = DEF_NUM_ACC,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int RD_DATA_W      = DEF_RD_DATA_W,
  parameter int WR_DATA_W      = DEF_WR_DATA_W,
  parameter int MEM_RD_LATENCY = DEF_MEM_RD_LATENCY  // 1..15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cpu_busy,
  input  logic [NUM_ACC-1:0]            acc_read_en,
  input  logic [NUM_ACC*ADDR_W-1:0]     acc_read_addr,
  input  logic [NUM_ACC-1:0]            acc_write_en,
  input  logic [NUM_ACC*ADDR_W-1:0]     acc_write_addr,
  input  logic [NUM_ACC*WR_DATA_W-1:0]  acc_write_data,
  output logic [RD_DATA_W-1:0]          acc_read_data,
  output logic [NUM_ACC-1:0]            acc_read_data_valid,
  output logic [NUM_ACC-1:0]            acc_write_done,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [WR_DATA_W-1:0]          mem_wr_data,
  input  logic [RD_DATA_W-1:0]          mem_rd_data
);

  localparam int IDX_W = idx_w(NUM_ACC);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   op_we_q, op_we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WR_DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RD_DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [NUM_ACC-1:0]     req_any;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  // Unpacked views of the packed per-accelerator buses.
  logic [ADDR_W-1:0]      rd_addr_a [NUM_ACC];
  logic [ADDR_W-1:0]      wr_addr_a [NUM_ACC];
  logic [WR_DATA_W-1:0]   wr_data_a [NUM_ACC];

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_unpack
    assign rd_addr_a[g] = acc_read_addr[g*ADDR_W +: ADDR_W];
    assign wr_addr_a[g] = acc_write_addr[g*ADDR_W +: ADDR_W];
    assign wr_data_a[g] = acc_write_data[g*WR_DATA_W +: WR_DATA_W];
  end

  assign req_any = acc_read_en | acc_write_en;

  acc_rr_picker #(
    .NUM_ACC (NUM_ACC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_any),
    .ptr     (rr_ptr_q),
    .grant   (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      op_we_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      op_we_q   <= op_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    idx_d               = idx_q;
    rr_ptr_d            = rr_ptr_q;
    op_we_d             = op_we_q;
    addr_d              = addr_q;
    wdata_d             = wdata_q;
    cnt_d               = cnt_q;
    rd_data_d           = rd_data_q;
    mem_en              = 1'b0;
    mem_we              = 1'b0;
    mem_addr            = '0;
    mem_wr_data         = '0;
    acc_read_data_valid = '0;
    acc_write_done      = '0;

    unique case (state_q)
      IDLE: begin
        if (!cpu_busy && pick_any) begin
          // Write wins when the picked accelerator asserts both.
          idx_d   = pick_idx;
          op_we_d = acc_write_en[pick_idx];
          addr_d  = acc_write_en[pick_idx] ? wr_addr_a[pick_idx] : rd_addr_a[pick_idx];
          wdata_d = acc_write_en[pick_idx] ? wr_data_a[pick_idx] : '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = op_we_q;
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        if (op_we_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_RD_LATENCY);
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_d = cnt_q - CNT_W'(1);
        // <= 1 rather than == 1 so a bad latency of 0 cannot hang here.
        if (cnt_q <= CNT_W'(1)) begin
          rd_data_d = mem_rd_data;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (op_we_q) acc_write_done[idx_q]      = 1'b1;
        else         acc_read_data_valid[idx_q] = 1'b1;
        rr_ptr_d = (idx_q == IDX_W'(NUM_ACC - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_read_data = rd_data_q;

endmodule
